// File: rtl/axi_stream_merger.sv
// Re-joins three count-delimited streams into one registered AXI-Stream.
// Each config drains port0_count, port1_count, port2_count words in order.
module axi_stream_merger #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 config_tvalid,
  input  logic [3*CNT_W-1:0]   config_tdata,
  output logic                 config_tready,
  input  logic                 s0_tvalid,
  input  logic [DATA_W-1:0]    s0_tdata,
  output logic                 s0_tready,
  input  logic                 s1_tvalid,
  input  logic [DATA_W-1:0]    s1_tdata,
  output logic                 s1_tready,
  input  logic                 s2_tvalid,
  input  logic [DATA_W-1:0]    s2_tdata,
  output logic                 s2_tready,
  output logic                 m_tvalid,
  output logic [DATA_W-1:0]    m_tdata,
  input  logic                 m_tready,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2,
    P2   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt0, cnt1, cnt2;
  logic [CNT_W-1:0]  cnt0_nxt, cnt1_nxt, cnt2_nxt;
  logic [CNT_W-1:0]  cfg0, cfg1, cfg2;
  logic              out_ready;
  logic              take;
  logic [DATA_W-1:0] take_data;
  logic              done_nxt;

  assign cfg0 = config_tdata[3*CNT_W-1 -: CNT_W];
  assign cfg1 = config_tdata[2*CNT_W-1 -: CNT_W];
  assign cfg2 = config_tdata[CNT_W-1:0];

  // Output slot is free if empty or being drained this cycle.
  assign out_ready = !m_tvalid || m_tready;

  always_comb begin
    state_nxt     = state;
    cnt0_nxt      = cnt0;
    cnt1_nxt      = cnt1;
    cnt2_nxt      = cnt2;
    config_tready = 1'b0;
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    s2_tready     = 1'b0;
    take          = 1'b0;
    take_data     = s0_tdata;
    done_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        config_tready = 1'b1;
        if (config_tvalid) begin
          cnt0_nxt = cfg0;
          cnt1_nxt = cfg1;
          cnt2_nxt = cfg2;
          if (cfg0 != '0)      state_nxt = P0;
          else if (cfg1 != '0) state_nxt = P1;
          else if (cfg2 != '0) state_nxt = P2;
          else                 state_nxt = IDLE;
        end
      end
      P0: begin
        s0_tready = out_ready;
        if (s0_tvalid && out_ready && cnt0 != '0) begin
          take      = 1'b1;
          take_data = s0_tdata;
          cnt0_nxt  = cnt0 - 1'b1;
          if (cnt0 == CNT_W'(1)) begin
            if (cnt1 != '0)      state_nxt = P1;
            else if (cnt2 != '0) state_nxt = P2;
            else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      P1: begin
        s1_tready = out_ready;
        if (s1_tvalid && out_ready && cnt1 != '0) begin
          take      = 1'b1;
          take_data = s1_tdata;
          cnt1_nxt  = cnt1 - 1'b1;
          if (cnt1 == CNT_W'(1)) begin
            if (cnt2 != '0) state_nxt = P2;
            else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      P2: begin
        s2_tready = out_ready;
        if (s2_tvalid && out_ready && cnt2 != '0) begin
          take      = 1'b1;
          take_data = s2_tdata;
          cnt2_nxt  = cnt2 - 1'b1;
          if (cnt2 == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
    endcase
    // No handshakes may complete while reset is held.
    if (rst) begin
      config_tready = 1'b0;
      s0_tready     = 1'b0;
      s1_tready     = 1'b0;
      s2_tready     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt0       <= '0;
      cnt1       <= '0;
      cnt2       <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt0       <= cnt0_nxt;
      cnt1       <= cnt1_nxt;
      cnt2       <= cnt2_nxt;
      frame_done <= done_nxt;
      if (take) begin
        m_tvalid <= 1'b1;
        m_tdata  <= take_data;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axi_stream_merger.md
# axi_stream_merger

Downstream companion to `axi_stream_router`. It re-joins the router's three output streams into one AXI-Stream, using the same 24-bit count configuration. For each accepted configuration it reads `port0_count` words from s0, then `port1_count` from s1, then `port2_count` from s2, and forwards them in that order through a registered output stage. It sits between the router's m0/m1/m2 outputs (possibly via per-port processing) and the single egress stream.

## Interface
Parameters:
- `DATA_W`, default 10: data width of all streams.
- `CNT_W`, default 8: width of each per-port count; `config_tdata` is `3*CNT_W` wide.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `config_tvalid`  in  1  configuration valid.
- `config_tdata`  in  3*CNT_W  {port0_count[23:16], port1_count[15:8], port2_count[7:0]}.
- `config_tready`  out  1  configuration accepted when high with `config_tvalid`.
- `s0_tvalid` / `s1_tvalid` / `s2_tvalid`  in  1  input stream valid.
- `s0_tdata` / `s1_tdata` / `s2_tdata`  in  DATA_W  input stream data.
- `s0_tready` / `s1_tready` / `s2_tready`  out  1  input stream ready.
- `m_tvalid`  out  1  merged output valid (registered).
- `m_tdata`  out  DATA_W  merged output data (registered).
- `m_tready`  in  1  downstream ready.
- `frame_done`  out  1  one-cycle pulse when the last word of a non-empty frame is accepted on an input.

## Operation
- FSM states: IDLE, P0, P1, P2. Reset state is IDLE.
- IDLE:
  - `config_tready`=1; all `sN_tready`=0.
  - On config handshake, latch the three counts into remaining-counters.
  - Next state is the first of P0/P1/P2 with a nonzero count.
  - If all counts are 0, the config is consumed, the FSM stays in IDLE, and there is no `frame_done`.
- Pn:
  - `config_tready`=0.
  - Only `sn_tready` may be high: `sn_tready = !m_tvalid || m_tready`. Other inputs' tready are 0; their data is ignored and left pending.
  - On `sn_tvalid && sn_tready`: load the output register (`m_tvalid`=1, `m_tdata`=`sn_tdata`) and decrement remaining[n].
  - When the accepted word has remaining[n]==1, go to the next higher port with a nonzero count, else IDLE. `frame_done` pulses in the same cycle as that last accepting edge's following cycle (registered, high for exactly one cycle).
- Output register:
  - Clears `m_tvalid` when `m_tready && m_tvalid` and no new word is loaded.
  - Holds `m_tdata` and `m_tvalid` stable while `m_tvalid && !m_tready`.
  - `m_tvalid` never drops without a handshake.
- Counts are unsigned, 0..2^CNT_W-1. A count of 0 skips that port. Counters do not wrap: they are only decremented when nonzero.
- Word order on `m`: all P0 words, then P1, then P2, each in input arrival order. No loss, no duplication.

## Timing
- Reset (async assert, sync-safe deassert on `clk`): state=IDLE, counters=0, `m_tvalid`=0, `m_tdata`=0, `frame_done`=0. While `rst` is high, `config_tready` and all `sN_tready` are forced to 0.
- Config accepted at edge N → Pn active and `sn_tready` may be high in cycle N+1.
- Input word accepted at edge K → on `m` from cycle K+1. Latency is 1 cycle.
- Throughput is 1 word/cycle within and across ports of one frame, with no bubble at port switch.
- Last word accepted at edge K → IDLE and `config_tready`=1 in cycle K+1. One bubble cycle per frame for the config handshake.
- A new config may be accepted while `m` still holds the previous frame's last word.
- Reset mid-frame: remaining counts are discarded, and any pending output word is dropped immediately.

## Test plan
- Config (3,2,1); s0=001,002,003, s1=101,102, s2=201, all valid from the start, `m_tready`=1 → `m`=001,002,003,101,102,201 on consecutive cycles. s1 and s2 are not accepted before their phase. `frame_done` pulses once. `config_tready` returns to 1 one cycle after 201 is accepted.
- Config (0,2,0); s0 and s2 held valid with data 0AA → only s1 words appear on `m`. `s0_tready` and `s2_tready` stay 0. FSM returns to IDLE after 2 words.
- Config (0,0,0) → accepted. `config_tready` is 1 the next cycle. No `m_tvalid`, no `frame_done`. A following config (1,0,0) works normally.
- Config (2,0,2); `m_tready` held 0 for 5 cycles after the first output → `m_tdata` stays stable, `s0_tready`=0 while stalled. After release, all 4 words arrive in order, none lost.
- Config (4,4,4); assert `rst` after 5 words → `m_tvalid` and all tready go to 0 immediately. After release, `config_tready`=1. Config (1,0,0) with s0=3FF → `m`=3FF exactly once.
- Random `m_tready` throttle and random input gaps over 50 frames with random counts ≤8 → output matches a scoreboard built from counts and per-port input queues.
